bsg_manycore_link_to_axil_rx_rd_resp: RTL and testbench
=======================================================

BSG_MANYCORE_LINK_TO_AXIL_RX_RD_RESP -- requirements
Module: bsg_manycore_link_to_axil_rx_rd_resp

Interface
REQ-001 SHALL have parameter axil_data_width_p, default 32: width of the AXI-lite read data and of each rx word.
REQ-002 SHALL have parameter axil_addr_width_p, default 32: width of the AXI-lite read address.
REQ-003 SHALL have parameter req_credits_width_p, default 4: width of the rx occupancy count input.
REQ-004 SHALL have parameter rx_data_addr_p, default 'h10: byte address of the rx data-pop register.
REQ-005 SHALL have parameter rx_count_addr_p, default 'h14: byte address of the rx occupancy register.
REQ-006 SHALL have parameter pop_cnt_addr_p, default 'h18: byte address of the popped-word counter register.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-008 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port araddr_i, input, axil_addr_width_p bits: AXI-lite read address.
REQ-010 SHALL have port arvalid_i, input, 1 bit: read-address valid.
REQ-011 SHALL have port arready_o, output, 1 bit: read-address ready.
REQ-012 SHALL have port rdata_o, output, axil_data_width_p bits: read data.
REQ-013 SHALL have port rresp_o, output, 2 bits: read response.
REQ-014 SHALL have port rvalid_o, output, 1 bit: read-data valid.
REQ-015 SHALL have port rready_i, input, 1 bit: read-data ready.
REQ-016 SHALL have port rx_data_i, input, axil_data_width_p bits: head word of the upstream rx word buffer.
REQ-017 SHALL have port rx_v_i, input, 1 bit: rx_data_i is valid.
REQ-018 SHALL have port rx_yumi_o, output, 1 bit: pops the head rx word.
REQ-019 SHALL have port rx_count_i, input, req_credits_width_p bits: rx buffer occupancy.

Function
REQ-020 SHALL implement a two-state FSM, IDLE and RESP.
REQ-021 SHALL drive arready_o high only in IDLE; an AR handshake (arvalid_i & arready_o) moves the FSM to RESP.
REQ-022 SHALL decode the address as araddr_i with bits [1:0] ignored, compared against the *_addr_p parameters with bits [1:0] likewise ignored.
REQ-023 SHALL handle a handshake on rx_data_addr_p with rx_v_i=1 as follows: rx_yumi_o=1 in the same cycle, rdata_o<=rx_data_i, rresp_o<=2'b00.
REQ-024 SHALL return rx_count_i zero-extended with OKAY on a handshake to rx_count_addr_p; the value is sampled in the handshake cycle.
REQ-025 SHALL return the pop counter, which counts rx_yumi_o pulses, as an axil_data_width_p-bit value with OKAY on a handshake to pop_cnt_addr_p; the counter wraps from all-ones to 0.
REQ-026 SHALL respond to a handshake on any other address with rdata_o=0 and rresp_o=2'b11 (DECERR), and SHALL NOT pop.
REQ-027 SHALL assert rvalid_o exactly one cycle after the AR handshake, and only in RESP.
REQ-028 SHALL hold rdata_o and rresp_o stable while rvalid_o & ~rready_i.
REQ-029 SHALL return the FSM to IDLE on rvalid_o & rready_i; the minimum spacing between reads is 2 cycles.
REQ-030 SHALL drive rx_yumi_o only in IDLE and only in the handshake cycle, so at most one pop occurs per read; rx_yumi_o is never high while rx_v_i is low.
REQ-031 SHALL count the pop in the pop counter when a pop coincides with a read of pop_cnt_addr_p; a subsequent read observes the incremented value.
REQ-032 SHALL ignore arvalid_i while in RESP; the address is accepted only after a return to IDLE.

Reset
REQ-033 SHALL, on reset_i=1 at a clock edge, force the FSM to IDLE, rvalid_o=0, rdata_o=0, rresp_o=0, and pop counter=0.
REQ-034 SHALL hold rx_yumi_o=0 and arready_o=0 during reset.
REQ-035 SHALL, on a reset in RESP, drop the pending response without re-popping, and SHALL NOT return the word already popped.

Configuration
REQ-036 SHALL, with BSG_AXIL_RX_EMPTY_ERR_EN defined, respond to a read of rx_data_addr_p with rx_v_i=0 with rdata_o=0 and rresp_o=2'b10 (SLVERR), with no pop.
REQ-037 SHALL, without BSG_AXIL_RX_EMPTY_ERR_EN, respond to the same case with rdata_o=0 and rresp_o=2'b00 (OKAY), with no pop; host software then detects empty via rx_count_addr_p.

Verification
REQ-038 SHALL cover: rx_v_i=1, rx_data_i=32'hCAFE_0001, read 'h10 with rready_i=1 -> rx_yumi_o pulse in the AR cycle; next cycle rvalid_o=1, rdata_o=32'hCAFE_0001, rresp_o=0.
REQ-039 SHALL cover: rx_v_i=0, read 'h10 -> rx_yumi_o=0; rresp_o=2'b10 with the macro defined, 2'b00 without; rdata_o=0 in both.
REQ-040 SHALL cover: rready_i held low 5 cycles after rvalid_o -> rdata_o/rresp_o stable, arready_o=0, and a second arvalid_i is not accepted until after the R handshake.
REQ-041 SHALL cover: three pops, then read 'h18 -> rdata_o=3; read 'h14 with rx_count_i=4'd7 -> rdata_o=7.
REQ-042 SHALL cover: read of 'h20 -> rresp_o=2'b11, rdata_o=0, no pop; and read of 'h13 (low bits ignored) -> decoded as 'h10.
REQ-043 SHALL cover: reset asserted while rvalid_o=1 -> next cycle rvalid_o=0, arready_o=0 during reset, pop counter=0 afterward.

Source files
------------

// File: rtl/bsg_manycore_link_to_axil_rx_rd_resp.sv
// AXI-lite read responder for the manycore rx word buffer. It pops rx data, reports occupancy, and reports a popped-word count.
// Optional feature: define BSG_AXIL_RX_EMPTY_ERR_EN to return SLVERR on a data read when the rx buffer is empty.
module bsg_manycore_link_to_axil_rx_rd_resp #(
  parameter int unsigned axil_data_width_p   = 32,
  parameter int unsigned axil_addr_width_p   = 32,
  parameter int unsigned req_credits_width_p = 4,
  parameter int unsigned rx_data_addr_p      = 'h10,
  parameter int unsigned rx_count_addr_p     = 'h14,
  parameter int unsigned pop_cnt_addr_p      = 'h18
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [axil_addr_width_p-1:0]   araddr_i,
  input  logic                           arvalid_i,
  output logic                           arready_o,
  output logic [axil_data_width_p-1:0]   rdata_o,
  output logic [1:0]                     rresp_o,
  output logic                           rvalid_o,
  input  logic                           rready_i,
  input  logic [axil_data_width_p-1:0]   rx_data_i,
  input  logic                           rx_v_i,
  output logic                           rx_yumi_o,
  input  logic [req_credits_width_p-1:0] rx_count_i
);

  localparam int unsigned dw_lp = axil_data_width_p;
  localparam int unsigned aw_lp = axil_addr_width_p;

  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;
  localparam logic [1:0] resp_decerr_lp = 2'b11;

  // Byte-lane bits are ignored on both sides of the compare.
  localparam logic [aw_lp-1:0] addr_mask_lp  = ~aw_lp'(3);
  localparam logic [aw_lp-1:0] rx_data_lp    = aw_lp'(rx_data_addr_p);
  localparam logic [aw_lp-1:0] rx_count_lp   = aw_lp'(rx_count_addr_p);
  localparam logic [aw_lp-1:0] pop_cnt_lp    = aw_lp'(pop_cnt_addr_p);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e             state_r, state_n;
  logic [dw_lp-1:0]   rdata_r, rdata_n;
  logic [1:0]         rresp_r, rresp_n;
  logic [dw_lp-1:0]   pop_cnt_r;
  logic               hit_data, hit_count, hit_pop;

  assign hit_data  = ((araddr_i ^ rx_data_lp)  & addr_mask_lp) == '0;
  assign hit_count = ((araddr_i ^ rx_count_lp) & addr_mask_lp) == '0;
  assign hit_pop   = ((araddr_i ^ pop_cnt_lp)  & addr_mask_lp) == '0;

  assign rvalid_o = (state_r == RESP);
  assign rdata_o  = rdata_r;
  assign rresp_o  = rresp_r;

  // Next-state, response capture, and the same-cycle pop strobe.
  always_comb begin
    state_n   = state_r;
    rdata_n   = rdata_r;
    rresp_n   = rresp_r;
    arready_o = 1'b0;
    rx_yumi_o = 1'b0;
    case (state_r)
      IDLE: begin
        arready_o = ~reset_i;
        if (arvalid_i && !reset_i) begin
          state_n = RESP;
          rdata_n = '0;
          rresp_n = resp_okay_lp;
          if (hit_data) begin
            if (rx_v_i) begin
              rx_yumi_o = 1'b1;
              rdata_n   = rx_data_i;
            end else begin
`ifdef BSG_AXIL_RX_EMPTY_ERR_EN
              rresp_n = resp_slverr_lp;
`else
              rresp_n = resp_okay_lp;
`endif
            end
          end else if (hit_count) begin
            rdata_n = dw_lp'(rx_count_i);
          end else if (hit_pop) begin
            rdata_n = pop_cnt_r;
          end else begin
            rresp_n = resp_decerr_lp;
          end
        end
      end
      RESP: begin
        if (rready_i) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r   <= IDLE;
      rdata_r   <= '0;
      rresp_r   <= resp_okay_lp;
      pop_cnt_r <= '0;
    end else begin
      state_r <= state_n;
      rdata_r <= rdata_n;
      rresp_r <= rresp_n;
      if (rx_yumi_o) pop_cnt_r <= pop_cnt_r + dw_lp'(1);
    end
  end

endmodule

// File: tb/tb_bsg_manycore_link_to_axil_rx_rd_resp.sv
// Directed bench for the AXI-lite rx read responder: pops, occupancy, pop counter, decode errors, stalls, and reset.
module tb_bsg_manycore_link_to_axil_rx_rd_resp;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] araddr_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rx_data_i;
  logic        rx_v_i;
  logic        rx_yumi_o;
  logic [3:0]  rx_count_i;

  int passes = 0;
  int checks = 0;

`ifdef BSG_AXIL_RX_EMPTY_ERR_EN
  localparam logic [1:0] empty_resp_lp = 2'b10;
`else
  localparam logic [1:0] empty_resp_lp = 2'b00;
`endif

  bsg_manycore_link_to_axil_rx_rd_resp dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .araddr_i   (araddr_i),
    .arvalid_i  (arvalid_i),
    .arready_o  (arready_o),
    .rdata_o    (rdata_o),
    .rresp_o    (rresp_o),
    .rvalid_o   (rvalid_o),
    .rready_i   (rready_i),
    .rx_data_i  (rx_data_i),
    .rx_v_i     (rx_v_i),
    .rx_yumi_o  (rx_yumi_o),
    .rx_count_i (rx_count_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One read with rready held high: AR handshake, one response cycle, back to IDLE.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic exp_yumi,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    araddr_i  = addr;
    arvalid_i = 1'b1;
    rready_i  = 1'b1;
    #1;
    chk({tag, "_arready"}, 32'(arready_o), 32'd1);
    chk({tag, "_yumi"}, 32'(rx_yumi_o), 32'(exp_yumi));
    tick();
    arvalid_i = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
    chk({tag, "_rdata"}, rdata_o, exp_data);
    chk({tag, "_rresp"}, 32'(rresp_o), 32'(exp_resp));
    tick();
    chk({tag, "_rvalid_drop"}, 32'(rvalid_o), 32'd0);
  endtask

  initial begin
    // Reset with an eager master and a full buffer; nothing may handshake or pop.
    reset_i    = 1'b1;
    araddr_i   = 32'h10;
    arvalid_i  = 1'b1;
    rready_i   = 1'b0;
    rx_data_i  = 32'hDEAD_BEEF;
    rx_v_i     = 1'b1;
    rx_count_i = 4'd0;
    #1;
    chk("rst_arready", 32'(arready_o), 32'd0);
    chk("rst_yumi", 32'(rx_yumi_o), 32'd0);
    tick();
    tick();
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_rresp", 32'(rresp_o), 32'd0);
    reset_i   = 1'b0;
    arvalid_i = 1'b0;
    #1;
    chk("idle_arready", 32'(arready_o), 32'd1);

    // Data pop with a valid head word.
    rx_data_i = 32'hCAFE_0001;
    do_read("pop1", 32'h10, 1'b1, 32'hCAFE_0001, 2'b00);

    // Empty buffer: no pop, zero data.
    rx_v_i = 1'b0;
    do_read("empty", 32'h10, 1'b0, 32'd0, empty_resp_lp);

    // Two more pops, then counter and occupancy reads.
    rx_v_i = 1'b1;
    rx_data_i = 32'h0000_0002;
    do_read("pop2", 32'h10, 1'b1, 32'h0000_0002, 2'b00);
    rx_data_i = 32'h0000_0003;
    do_read("pop3", 32'h10, 1'b1, 32'h0000_0003, 2'b00);
    do_read("popcnt3", 32'h18, 1'b0, 32'd3, 2'b00);
    rx_count_i = 4'd7;
    do_read("count7", 32'h14, 1'b0, 32'd7, 2'b00);

    // Unmapped address, then low-bit aliasing of the data register.
    do_read("decerr", 32'h20, 1'b0, 32'd0, 2'b11);
    do_read("popcnt_still3", 32'h18, 1'b0, 32'd3, 2'b00);
    rx_data_i = 32'h0000_0055;
    do_read("alias13", 32'h13, 1'b1, 32'h0000_0055, 2'b00);
    do_read("popcnt4", 32'h1B, 1'b0, 32'd4, 2'b00);

    // Back-pressure: response held 5 cycles while a second AR waits.
    rx_data_i = 32'h0000_00AA;
    araddr_i  = 32'h10;
    arvalid_i = 1'b1;
    rready_i  = 1'b0;
    #1;
    chk("stall_yumi", 32'(rx_yumi_o), 32'd1);
    tick();
    araddr_i   = 32'h14;
    rx_count_i = 4'd9;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rvalid", 32'(rvalid_o), 32'd1);
      chk("stall_rdata", rdata_o, 32'h0000_00AA);
      chk("stall_rresp", 32'(rresp_o), 32'd0);
      chk("stall_arready", 32'(arready_o), 32'd0);
      chk("stall_no_pop", 32'(rx_yumi_o), 32'd0);
      tick();
    end
    rready_i = 1'b1;
    tick();
    chk("stall_release_rvalid", 32'(rvalid_o), 32'd0);
    chk("stall_release_arready", 32'(arready_o), 32'd1);
    tick();
    arvalid_i = 1'b0;
    chk("second_rvalid", 32'(rvalid_o), 32'd1);
    chk("second_rdata", rdata_o, 32'd9);
    tick();
    chk("second_done", 32'(rvalid_o), 32'd0);
    do_read("popcnt5", 32'h18, 1'b0, 32'd5, 2'b00);

    // Reset while a popped word is pending: response dropped, counter cleared.
    rx_data_i = 32'h0000_00BB;
    araddr_i  = 32'h10;
    arvalid_i = 1'b1;
    rready_i  = 1'b0;
    tick();
    chk("pend_rvalid", 32'(rvalid_o), 32'd1);
    chk("pend_rdata", rdata_o, 32'h0000_00BB);
    reset_i = 1'b1;
    #1;
    chk("rst2_arready", 32'(arready_o), 32'd0);
    chk("rst2_yumi", 32'(rx_yumi_o), 32'd0);
    tick();
    chk("rst2_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst2_rdata", rdata_o, 32'd0);
    reset_i   = 1'b0;
    arvalid_i = 1'b0;
    do_read("popcnt_after_rst", 32'h18, 1'b0, 32'd0, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
